// File: rtl/usb_ls_rx.sv
// Low-speed USB receive front end: 8x oversampled bit recovery, NRZI decode, SYNC detection,
// bit unstuffing, byte assembly and EOP detection, with single-cycle result strobes.
module usb_ls_rx #(
    parameter bit          LOW_SPEED = 1'b1,
    parameter int unsigned SAMPLE_PH = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       usb_dp,
    input  logic       usb_dm,
    input  logic       rx_en,
    output logic [1:0] line_state,
    output logic       rx_active,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_eop,
    output logic       rx_err
);

    localparam logic       JDp      = ~LOW_SPEED;
    localparam logic       JDm      = LOW_SPEED;
    localparam logic [2:0] SamplePh = 3'(SAMPLE_PH);

    localparam logic [1:0] LsSe0 = 2'd0;
    localparam logic [1:0] LsJ   = 2'd1;
    localparam logic [1:0] LsK   = 2'd2;
    localparam logic [1:0] LsSe1 = 2'd3;

    typedef enum logic [2:0] {StIdle, StSync, StData, StEop, StWaitJ} state_e;

    state_e      state_q, state_d;
    logic        dp_s1_q, dp_s2_q, dm_s1_q, dm_s2_q;
    logic [1:0]  ls_prev_q;
    logic [2:0]  phase_q, phase_d;
    logic [1:0]  prev_jk_q, prev_jk_d;
    logic [2:0]  zero_q, zero_d;
    logic [2:0]  ones_q, ones_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        rx_active_q, rx_active_d;
    logic        rx_valid_q, rx_valid_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_eop_q, rx_eop_d;
    logic        rx_err_q, rx_err_d;

    logic        sample;
    logic        ls_j, ls_k, ls_jk, ls_se0, ls_se1;
    logic        dec_bit, stuff_slot, stuff_err;

    // Two-flop synchronizer; idles at J so reset looks like a quiet bus.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            dp_s1_q <= JDp;
            dp_s2_q <= JDp;
            dm_s1_q <= JDm;
            dm_s2_q <= JDm;
        end else begin
            dp_s1_q <= usb_dp;
            dp_s2_q <= dp_s1_q;
            dm_s1_q <= usb_dm;
            dm_s2_q <= dm_s1_q;
        end
    end

    always_comb begin
        if (dp_s2_q == dm_s2_q) begin
            line_state = dp_s2_q ? LsSe1 : LsSe0;
        end else if (dp_s2_q == JDp) begin
            line_state = LsJ;
        end else begin
            line_state = LsK;
        end
    end

    // Bit-clock recovery: any line change restarts the phase, sampling mid-bit.
    always_comb begin
        phase_d = (line_state != ls_prev_q) ? 3'd0 : phase_q + 3'd1;
    end

    assign sample     = (phase_d == SamplePh);
    assign ls_j       = (line_state == LsJ);
    assign ls_k       = (line_state == LsK);
    assign ls_jk      = ls_j || ls_k;
    assign ls_se0     = (line_state == LsSe0);
    assign ls_se1     = (line_state == LsSe1);
    assign dec_bit    = (line_state == prev_jk_q);
    assign stuff_slot = (ones_q == 3'd6);
    assign stuff_err  = stuff_slot && dec_bit;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ls_prev_q <= LsJ;
            phase_q   <= 3'd0;
        end else begin
            ls_prev_q <= line_state;
            phase_q   <= phase_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        if (!rx_en) begin
            state_d = StIdle;
        end else if (sample) begin
            unique case (state_q)
                StIdle: begin
                    if (ls_k) state_d = StSync;
                end
                StSync: begin
                    if (ls_jk) begin
                        if (dec_bit) state_d = (zero_q >= 3'd3) ? StData : StIdle;
                    end else begin
                        state_d = StIdle;
                    end
                end
                StData: begin
                    if (ls_jk) begin
                        if (stuff_err) state_d = StWaitJ;
                    end else if (ls_se0 && bit_q == 3'd0) begin
                        state_d = StEop;
                    end else begin
                        state_d = StWaitJ;
                    end
                end
                StEop: begin
                    if (ls_j) begin
                        state_d = StIdle;
                    end else if (!ls_se0) begin
                        state_d = StWaitJ;
                    end
                end
                StWaitJ: begin
                    if (ls_j) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Datapath: NRZI reference, SYNC zero run, stuffing run, bit count and shift register.
    always_comb begin
        prev_jk_d = prev_jk_q;
        zero_d    = zero_q;
        ones_d    = ones_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        if (sample && ls_jk) begin
            prev_jk_d = line_state;
            unique case (state_q)
                StIdle: begin
                    if (ls_k) zero_d = 3'd1;
                end
                StSync: begin
                    if (!dec_bit) begin
                        zero_d = (zero_q == 3'd7) ? 3'd7 : zero_q + 3'd1;
                    end else begin
                        ones_d  = 3'd0;
                        bit_d   = 3'd0;
                        shift_d = 8'h00;
                    end
                end
                StData: begin
                    if (stuff_slot) begin
                        ones_d = 3'd0;
                    end else begin
                        ones_d  = dec_bit ? ones_q + 3'd1 : 3'd0;
                        shift_d = {dec_bit, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            prev_jk_q <= LsJ;
            zero_q    <= 3'd0;
            ones_q    <= 3'd0;
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
        end else begin
            prev_jk_q <= prev_jk_d;
            zero_q    <= zero_d;
            ones_q    <= ones_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
        end
    end

    // FSM outputs
    always_comb begin
        rx_valid_d = 1'b0;
        rx_eop_d   = 1'b0;
        rx_err_d   = 1'b0;
        rx_data_d  = rx_data_q;
        if (rx_en && sample) begin
            unique case (state_q)
                StData: begin
                    if (ls_jk) begin
                        if (stuff_err) begin
                            rx_err_d = 1'b1;
                        end else if (!stuff_slot && bit_q == 3'd7) begin
                            rx_valid_d = 1'b1;
                            rx_data_d  = {dec_bit, shift_q[7:1]};
                        end
                    end else if (!(ls_se0 && bit_q == 3'd0)) begin
                        rx_err_d = 1'b1;
                    end
                end
                StEop: begin
                    if (ls_k || ls_se1) begin
                        rx_err_d = 1'b1;
                    end else if (ls_j) begin
                        rx_eop_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        rx_active_d = (state_d == StData) || (state_d == StEop);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_active_q <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_eop_q    <= 1'b0;
            rx_err_q    <= 1'b0;
        end else begin
            rx_active_q <= rx_active_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            rx_eop_q    <= rx_eop_d;
            rx_err_q    <= rx_err_d;
        end
    end

    assign rx_active = rx_active_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign rx_eop    = rx_eop_q;
    assign rx_err    = rx_err_q;

endmodule

// File: tb/tb_usb_ls_rx.sv
// Self-checking bench for usb_ls_rx: encodes packets (stuffing, NRZI, EOP) onto the pins and
// compares received bytes and strobes with the packet-level expectation.
module tb_usb_ls_rx;

    localparam logic [1:0] SE0 = 2'd0;
    localparam logic [1:0] J   = 2'd1;
    localparam logic [1:0] K   = 2'd2;

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    logic       usb_dp = 1'b0;
    logic       usb_dm = 1'b1;
    logic       rx_en  = 1'b1;
    logic [1:0] line_state;
    logic       rx_active, rx_valid, rx_eop, rx_err;
    logic [7:0] rx_data;

    int vectors     = 0;
    int miscompares = 0;

    byte unsigned got_q[$];
    int           eop_cnt = 0;
    int           err_cnt = 0;
    logic         abort_act_before, abort_act_after;

    usb_ls_rx dut (
        .clk       (clk),
        .resetn    (resetn),
        .usb_dp    (usb_dp),
        .usb_dm    (usb_dm),
        .rx_en     (rx_en),
        .line_state(line_state),
        .rx_active (rx_active),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_eop    (rx_eop),
        .rx_err    (rx_err)
    );

    always #5 clk = ~clk;

    // Strobe monitor: collects bytes, counts terminations, checks strobe exclusivity and that
    // rx_active is high with rx_valid but already low with rx_eop/rx_err.
    always @(negedge clk) begin
        if (resetn && (rx_valid || rx_eop || rx_err)) begin
            if (rx_valid) got_q.push_back(rx_data);
            if (rx_eop) eop_cnt++;
            if (rx_err) err_cnt++;
            vectors++;
            if (int'(rx_valid) + int'(rx_eop) + int'(rx_err) != 1) begin
                miscompares++;
                $display("FAIL strobe_excl: valid=%b eop=%b err=%b, want one-hot",
                         rx_valid, rx_eop, rx_err);
            end
            vectors++;
            if (rx_active !== rx_valid) begin
                miscompares++;
                $display("FAIL strobe_active: rx_active=%b, want %b", rx_active, rx_valid);
            end
        end
    end

    task automatic clr_mon();
        got_q   = {};
        eop_cnt = 0;
        err_cnt = 0;
    endtask

    task automatic put_level(input logic [1:0] ls, input int cycles);
        case (ls)
            2'd0:    begin usb_dp = 1'b0; usb_dm = 1'b0; end
            2'd1:    begin usb_dp = 1'b0; usb_dm = 1'b1; end
            2'd2:    begin usb_dp = 1'b1; usb_dm = 1'b0; end
            default: begin usb_dp = 1'b1; usb_dm = 1'b1; end
        endcase
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Packet-level reference: which bytes arrive and how the packet ends.
    function automatic void model_rx(input byte unsigned data[$], input int n_extra,
                                     input bit omit, output byte unsigned exp[$],
                                     output int e_eop, output int e_err);
        int         run;
        logic [7:0] cur;
        run   = 0;
        exp   = {};
        e_eop = (n_extra == 0) ? 1 : 0;
        e_err = (n_extra != 0) ? 1 : 0;
        foreach (data[k]) begin
            cur = data[k];
            for (int b = 0; b < 8; b++) begin
                run = cur[b] ? run + 1 : 0;
                if (omit && run == 7) begin
                    e_err = 1;
                    e_eop = 0;
                    return;
                end
            end
            exp.push_back(data[k]);
        end
    endfunction

    // cut_kind 1: drop rx_en before bit cut_at; 2: assert reset before bit cut_at and stop.
    task automatic send_packet(input byte unsigned data[$], input int n_extra, input bit omit,
                               input bit jitter, input int cut_at, input int cut_kind);
        bit         bits[$];
        int         ones;
        int         per;
        int         jsel;
        logic [1:0] lvl;
        logic [7:0] cur;
        bit         v;
        for (int i = 0; i < 7; i++) bits.push_back(1'b0);
        bits.push_back(1'b1);
        ones = 0;
        for (int k = 0; k < data.size() + n_extra; k++) begin
            cur = (k < data.size()) ? data[k] : 8'($urandom_range(0, 255));
            for (int b = 0; b < ((k < data.size()) ? 8 : 1); b++) begin
                v = cur[b];
                bits.push_back(v);
                ones = v ? ones + 1 : 0;
                if (ones == 6 && !omit) begin
                    bits.push_back(1'b0);
                    ones = 0;
                end
            end
        end
        lvl  = J;
        jsel = int'($urandom_range(0, 1));
        for (int i = 0; i < bits.size(); i++) begin
            if (i == cut_at && cut_kind == 1) begin
                abort_act_before = rx_active;
                rx_en = 1'b0;
                @(posedge clk);
                #1;
                abort_act_after = rx_active;
            end
            if (i == cut_at && cut_kind == 2) begin
                resetn = 1'b0;
                @(posedge clk);
                #1;
                return;
            end
            if (!bits[i]) lvl = (lvl == J) ? K : J;
            per = jitter ? ((((i + jsel) % 2) != 0) ? 9 : 7) : 8;
            put_level(lvl, per);
        end
        put_level(SE0, 16);
        put_level(J, 24);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (line_state !== J) begin
            miscompares++; $display("FAIL reset_line_state: got %0d want 1", line_state);
        end
        vectors++;
        if ({rx_active, rx_valid, rx_eop, rx_err} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 0000", {rx_active, rx_valid, rx_eop, rx_err});
        end
        vectors++;
        if (rx_data !== 8'h00) begin
            miscompares++; $display("FAIL reset_data: got %h want 00", rx_data);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        put_level(J, 16);
    endtask

    task automatic test_latency();
        clr_mon();
        usb_dp = 1'b1;
        usb_dm = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (line_state !== J) begin
            miscompares++; $display("FAIL latency_1cyc: got %0d want 1", line_state);
        end
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (line_state !== K) begin
            miscompares++; $display("FAIL latency_2cyc: got %0d want 2", line_state);
        end
        @(posedge clk);
        #1;
        put_level(K, 4);
        put_level(J, 40);
        vectors++;
        if (got_q.size() + eop_cnt + err_cnt != 0) begin
            miscompares++;
            $display("FAIL glitch_silent: got %0d strobes want 0", got_q.size() + eop_cnt + err_cnt);
        end
    endtask

    task automatic test_packet(input string name, input byte unsigned d[$], input int n_extra,
                               input bit omit, input bit jitter);
        byte unsigned exp[$];
        int           e_eop, e_err;
        clr_mon();
        send_packet(d, n_extra, omit, jitter, -1, 0);
        model_rx(d, n_extra, omit, exp, e_eop, e_err);
        vectors++;
        if (got_q.size() != exp.size()) begin
            miscompares++;
            $display("FAIL %s_count: got %0d bytes want %0d", name, got_q.size(), exp.size());
        end
        foreach (exp[i]) begin
            if (i < got_q.size()) begin
                vectors++;
                if (got_q[i] !== exp[i]) begin
                    miscompares++;
                    $display("FAIL %s_byte%0d: got %h want %h", name, i, got_q[i], exp[i]);
                end
            end
        end
        vectors++;
        if (eop_cnt != e_eop) begin
            miscompares++; $display("FAIL %s_eop: got %0d want %0d", name, eop_cnt, e_eop);
        end
        vectors++;
        if (err_cnt != e_err) begin
            miscompares++; $display("FAIL %s_err: got %0d want %0d", name, err_cnt, e_err);
        end
        if (exp.size() != 0) begin
            vectors++;
            if (rx_data !== exp[exp.size() - 1]) begin
                miscompares++;
                $display("FAIL %s_hold: got %h want %h", name, rx_data, exp[exp.size() - 1]);
            end
        end
    endtask

    task automatic test_clean();
        test_packet("clean", {8'hC3, 8'hA5}, 0, 1'b0, 1'b0);
    endtask

    task automatic test_stuffing();
        test_packet("stuff", {8'hFF, 8'h01}, 0, 1'b0, 1'b0);
        test_packet("nostuff", {8'hFF, 8'h01}, 0, 1'b1, 1'b0);
        test_packet("stuff_tail", {8'h12, 8'hFC}, 0, 1'b0, 1'b0);
    endtask

    task automatic test_jitter();
        test_packet("jitter", {8'hC3, 8'hA5}, 0, 1'b0, 1'b1);
    endtask

    task automatic test_truncation();
        test_packet("trunc", {8'h2D}, 3, 1'b0, 1'b0);
        test_packet("after_trunc", {8'($urandom_range(0, 255)), 8'h7E}, 0, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        clr_mon();
        send_packet({8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))}, 0, 1'b0, 1'b0, 12, 1);
        vectors++;
        if (abort_act_before !== 1'b1) begin
            miscompares++; $display("FAIL abort_active_pre: got %b want 1", abort_act_before);
        end
        vectors++;
        if (abort_act_after !== 1'b0) begin
            miscompares++; $display("FAIL abort_active_post: got %b want 0", abort_act_after);
        end
        vectors++;
        if (got_q.size() + eop_cnt + err_cnt != 0) begin
            miscompares++;
            $display("FAIL abort_silent: got %0d strobes want 0", got_q.size() + eop_cnt + err_cnt);
        end
        rx_en = 1'b1;
        put_level(J, 16);
        test_packet("after_abort", {8'($urandom_range(0, 255)), 8'hFF, 8'h80}, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        clr_mon();
        send_packet({8'h5A, 8'h3C}, 0, 1'b0, 1'b0, 20, 2);
        vectors++;
        if ({line_state, rx_active, rx_valid, rx_eop, rx_err, rx_data} !== {J, 12'h000}) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: ls=%0d act=%b v=%b eop=%b err=%b data=%h want J,0",
                     line_state, rx_active, rx_valid, rx_eop, rx_err, rx_data);
        end
        usb_dp = 1'b0;
        usb_dm = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        put_level(J, 24);
        vectors++;
        if (got_q.size() != 1 || eop_cnt != 0 || err_cnt != 0) begin
            miscompares++;
            $display("FAIL reset_mid_strobes: got %0d bytes %0d eop %0d err want 1,0,0",
                     got_q.size(), eop_cnt, err_cnt);
        end else begin
            vectors++;
            if (got_q[0] !== 8'h5A) begin
                miscompares++; $display("FAIL reset_mid_byte: got %h want 5a", got_q[0]);
            end
        end
    endtask

    task automatic test_random();
        repeat (16) begin
            byte unsigned d[$];
            int           n;
            n = int'($urandom_range(1, 4));
            d = {};
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 3))
                    0:       d.push_back(8'hFF);
                    1:       d.push_back(8'($urandom_range(0, 255)) | 8'hF8);
                    default: d.push_back(8'($urandom_range(0, 255)));
                endcase
            end
            test_packet("random", d, 0, 1'b0, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_clean();
        test_stuffing();
        test_jitter();
        test_truncation();
        test_abort();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/usb_ls_rx.md
# usb_ls_rx

Low-speed (1.5 Mbit/s) USB receive front end for the USB host controller-input path. It runs on the 12 MHz USB clock, giving 8× oversampling. It synchronizes the raw D+/D- pins, recovers bit timing, and performs NRZI decoding, SYNC detection, bit unstuffing, byte assembly and EOP detection. Received bytes are handed to the packet/protocol layer as single-cycle strobes.

## Interface
- LOW_SPEED, 1: line polarity. 1: J=(dp,dm)=(0,1), K=(1,0). 0: J=(1,0), K=(0,1).
- SAMPLE_PH, 3: phase-counter value at which a bit is sampled (0..7).

- clk  in  1  12 MHz USB clock; all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- usb_dp  in  1  raw D+ pin, asynchronous
- usb_dm  in  1  raw D- pin, asynchronous
- rx_en  in  1  receiver enable; host drives low while transmitting
- line_state  out  2  synchronized line state: 0=SE0, 1=J, 2=K, 3=SE1
- rx_active  out  1  high from SYNC accepted until EOP, error or abort
- rx_valid  out  1  one-cycle strobe, rx_data valid
- rx_data  out  8  received byte, LSB first on wire; held until next rx_valid
- rx_eop  out  1  one-cycle strobe, clean end of packet
- rx_err  out  1  one-cycle strobe, packet aborted by line/stuff error

## Operation
- Synchronizer: two flops on each of dp and dm; they reset to the J levels. line_state is decoded from stage 2 (2-cycle latency).
- Phase counter: 3 bits.
  - Loads 0 in any cycle where line_state differs from the previous cycle; otherwise increments, wrapping 7→0.
  - A sample event occurs when counter == SAMPLE_PH. That is 3 cycles after an edge, then every 8 cycles with no edge.
- NRZI: decoded bit = 1 if the sampled state equals the previous sampled J/K state, else 0.
- FSM states: IDLE, SYNC, DATA, EOP, WAIT_J.
  - **IDLE:** on a K sample with rx_en=1 → SYNC; zero-count=1, previous=K.
  - **SYNC:**
    - Decoded 0 → zero-count++.
    - Decoded 1 with zero-count ≥ 3 → DATA; rx_active=1; bit count, ones count and shift register cleared.
    - Decoded 1 with zero-count < 3, or SE0 sampled → IDLE silently, no rx_err.
    - SE1 sampled → IDLE silently.
  - **DATA:**
    - J/K sample: NRZI-decode, then unstuff.
      - Ones count tracks consecutive decoded 1s.
      - After 6 ones, the next bit must be 0; it is discarded and the ones count cleared.
      - If that bit is 1 → stuff error.
      - Otherwise shift the bit in at the MSB (LSB-first assembly) and increment the bit count.
    - On the 8th bit: rx_data ← byte, rx_valid pulse, bit count ← 0.
    - SE0 sample with bit count == 0 → EOP.
    - SE0 sample with bit count ≠ 0 → error.
    - SE1 sample → error.
  - **EOP:**
    - Further SE0 samples ignored.
    - J sample → rx_eop pulse, rx_active←0, → IDLE.
    - K or SE1 sample → error.
  - **Error:** rx_err pulse, rx_active←0, → WAIT_J.
  - **WAIT_J:** → IDLE on first J sample; no strobes.
- rx_en=0 in any state: next state IDLE, rx_active←0, no rx_valid/rx_eop/rx_err that cycle or after. The synchronizer and line_state keep running.
- A stuffed bit following the final data bit is consumed before EOP and does not break alignment.
- rx_valid, rx_eop and rx_err are mutually exclusive; at most one of them fires in any cycle.

## Timing
- Reset outputs: line_state=1 (J), rx_active=0, rx_valid=0, rx_data=8'h00, rx_eop=0, rx_err=0.
- Pin edge → line_state: 2 cycles. line_state edge → sample: SAMPLE_PH cycles.
- rx_active rises 1 cycle after the SYNC-terminating K sample.
- rx_valid: 1 cycle after the sample of the byte's 8th data bit.
- rx_eop / rx_err: 1 cycle after the sample that triggers them. rx_active falls in the same cycle as that strobe.
- Drift tolerance: bit periods of 7–9 cycles. Phase re-aligns on every J/K edge; the longest edgeless run is 7 bit times.
- Reset asserted mid-packet: all outputs take their reset values on the next edge; no strobes.

## Test plan
- Reset: hold resetn=0 for 4 cycles with the line at J → line_state=1, all other outputs 0, rx_data=8'h00.
- Clean packet: drive SYNC, 0xC3, 0xA5, then SE0 for 16 cycles and J, at 8 cycles/bit → exactly two rx_valid (0xC3, then 0xA5), one rx_eop, rx_err never high.
- Bit stuffing:
  - Send 0xFF, 0x01 with the stuffed 0 inserted → rx_data 0xFF then 0x01.
  - Repeat with the stuffed bit omitted (7 ones) → one rx_err, no further rx_valid until J idle.
- Jitter: same packet as the clean case, with bit periods alternating 7 and 9 cycles → identical bytes and rx_eop.
- Truncation: send SYNC, 0x2D, 3 bits, then SE0 → rx_valid for 0x2D, then rx_err, no rx_eop. A following clean packet is received correctly.
- Abort: drop rx_en mid-byte → rx_active=0 on the next cycle, no strobes. Re-enabling at idle and sending a packet → normal reception.
